// File: rtl/clock_disp_pkg.sv
// clock_disp_pkg: shared display-scan constants, index-width helper and update FSM states
package clock_disp_pkg;
    localparam int NUM_DIGITS_DEF = 6;
    localparam logic [3:0] BCD_MAX = 4'd9;
    typedef enum logic [0:0] {IDLE = 1'b0, PENDING = 1'b1} upd_state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/scan_timer.sv
// scan_timer: slot counter, digit index, frame pulse and blink phase; in clk/reset_n, out cnt/idx/at_start/frame_start/blink_on
module scan_timer
    import clock_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int SLOT_CYCLES  = 5000,
    parameter int BLINK_FRAMES = 64,
    localparam int IW = idx_w(NUM_DIGITS),
    localparam int CW = idx_w(SLOT_CYCLES)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [CW-1:0] cnt,
    output logic [IW-1:0] idx,
    output logic          at_start,
    output logic          frame_start,
    output logic          blink_on
);
    localparam int FW = idx_w(BLINK_FRAMES);
    logic [FW-1:0] fcnt;
    logic slot_end, idx_end, fcnt_end;
    assign slot_end = cnt == CW'(SLOT_CYCLES - 1);
    assign idx_end  = idx == IW'(NUM_DIGITS - 1);
    assign fcnt_end = fcnt == FW'(BLINK_FRAMES - 1);
    assign at_start = cnt == '0 && idx == '0;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= '0;
            idx         <= '0;
            fcnt        <= '0;
            blink_on    <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx_end ? '0 : idx + 1'b1;
            if (slot_end && idx_end) begin
                fcnt     <= fcnt_end ? '0 : fcnt + 1'b1;
                blink_on <= blink_on ^ fcnt_end;
            end
            frame_start <= at_start;
        end
    end
endmodule

// File: rtl/display_scan_controller.sv
// display_scan_controller: frame buffer + update handshake + digit mux/enables for a shared BCD decoder; in upd_valid/upd_digits/blank_mask/blink_mask, out upd_ready/bcd_out/dec_reset/digit_sel_n/frame_start/bcd_err
module display_scan_controller
    import clock_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = NUM_DIGITS_DEF,
    parameter int SLOT_CYCLES  = 5000,
    parameter int GUARD_CYCLES = 50,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    upd_valid,
    output logic                    upd_ready,
    input  logic [4*NUM_DIGITS-1:0] upd_digits,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [3:0]              bcd_out,
    output logic                    dec_reset,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_start,
    output logic                    bcd_err
);
    localparam int IW = idx_w(NUM_DIGITS);
    localparam int CW = idx_w(SLOT_CYCLES);
    upd_state_t state;
    logic [4*NUM_DIGITS-1:0] pend, fb, fb_nx;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic at_start, blink_on, copy, bad, lit;
    scan_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .cnt        (cnt),
        .idx        (idx),
        .at_start   (at_start),
        .frame_start(frame_start),
        .blink_on   (blink_on)
    );
    always_comb begin
        bad = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++)
            bad = bad | (upd_digits[4*i +: 4] > BCD_MAX);
    end
    assign upd_ready = state == IDLE;
    // the copy edge is the one that loads digit 0 of the new frame, so bypass pend into bcd_out
    assign copy  = state == PENDING && at_start;
    assign fb_nx = copy ? pend : fb;
    assign lit   = cnt >= CW'(GUARD_CYCLES) && !blank_mask[idx] && (!blink_mask[idx] || blink_on);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            pend        <= '0;
            fb          <= '0;
            bcd_err     <= 1'b0;
            bcd_out     <= '0;
            dec_reset   <= 1'b1;
            digit_sel_n <= '1;
        end else begin
            fb          <= fb_nx;
            bcd_out     <= fb_nx[{idx, 2'b00} +: 4];
            dec_reset   <= 1'b0;
            digit_sel_n <= ~(NUM_DIGITS'(lit) << idx);
            if (copy)
                state <= IDLE;
            else if (upd_valid && upd_ready) begin
                pend    <= upd_digits;
                state   <= PENDING;
                bcd_err <= bcd_err | bad;
            end
        end
    end
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed scan/update/blink/reset bench with a scoreboard of pending frame updates
module tb_display_scan_controller;
    localparam int N = 4;
    localparam int S = 8;
    localparam int G = 2;
    localparam int B = 2;
    localparam int F = S * N;
    localparam logic [N-1:0] ALL1 = '1;
    typedef struct {
        logic [4*N-1:0] d;
        int             at;
    } upd_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic upd_valid = 1'b0;
    logic upd_ready;
    logic [4*N-1:0] upd_digits = '0;
    logic [N-1:0] blank_mask = '0;
    logic [N-1:0] blink_mask = '0;
    logic [3:0] bcd_out;
    logic dec_reset;
    logic [N-1:0] digit_sel_n;
    logic frame_start;
    logic bcd_err;
    int total = 0;
    int bad = 0;
    int c = -1;
    upd_t sb[$];
    logic [4*N-1:0] disp = '0;
    logic err_m = 1'b0;
    logic rdy_m = 1'b1;
    logic [N-1:0] blank_m = '0;
    logic [N-1:0] blink_m = '0;

    always #5 clk = ~clk;

    display_scan_controller #(
        .NUM_DIGITS  (N),
        .SLOT_CYCLES (S),
        .GUARD_CYCLES(G),
        .BLINK_FRAMES(B)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_digits (upd_digits),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .bcd_out    (bcd_out),
        .dec_reset  (dec_reset),
        .digit_sel_n(digit_sel_n),
        .frame_start(frame_start),
        .bcd_err    (bcd_err)
    );

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, o, e, c);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_upd_ready"}, 32'(upd_ready), 32'd1);
        chk({tag, "_bcd_out"}, 32'(bcd_out), 32'd0);
        chk({tag, "_dec_reset"}, 32'(dec_reset), 32'd1);
        chk({tag, "_digit_sel_n"}, 32'(digit_sel_n), 32'(ALL1));
        chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        chk({tag, "_bcd_err"}, 32'(bcd_err), 32'd0);
    endtask

    // one clock: record what the DUT accepted/sampled at the edge, then check the new cycle
    task automatic tick();
        upd_t u;
        int ix;
        int sl;
        logic on;
        logic lit;
        logic [N-1:0] sel;
        @(posedge clk);
        if (upd_valid && rdy_m) begin
            u.d  = upd_digits;
            u.at = ((c + 2 + F - 1) / F) * F;
            sb.push_back(u);
            for (int i = 0; i < N; i++)
                if (upd_digits[4*i +: 4] > 4'd9) err_m = 1'b1;
        end
        blank_m = blank_mask;
        blink_m = blink_mask;
        c++;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].at == c) begin
            u = sb.pop_front();
            disp = u.d;
        end
        rdy_m = sb.size() == 0;
        ix  = (c / S) % N;
        sl  = c % S;
        on  = ((c / F) / B) % 2 == 0;
        lit = sl >= G && !blank_m[ix] && (!blink_m[ix] || on);
        sel = '1;
        if (lit) sel[ix] = 1'b0;
        chk("frame_start", 32'(frame_start), 32'(c % F == 0));
        chk("bcd_out", 32'(bcd_out), 32'(disp[4*ix +: 4]));
        chk("digit_sel_n", 32'(digit_sel_n), 32'(sel));
        chk("dec_reset", 32'(dec_reset), 32'd0);
        chk("upd_ready", 32'(upd_ready), 32'(rdy_m));
        chk("bcd_err", 32'(bcd_err), 32'(err_m));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int k);
        for (int i = 0; i < F; i++) begin
            tick();
            if (c % F == k) break;
        end
    endtask

    task automatic offer(input logic [4*N-1:0] d);
        upd_valid  = 1'b1;
        upd_digits = d;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("reset");
        reset_n = 1'b1;
        chk_reset("released");
        run(F + 2);

        run_to(10);
        offer(16'h1234);
        run_to(1);

        run_to(0);
        offer(16'h5678);
        run(40);

        blink_mask = 4'b0001;
        blank_mask = 4'b0010;
        run(5 * F);
        blink_mask = '0;
        blank_mask = '0;
        tick();

        run_to(5);
        offer(16'h12C4);
        run_to(3);
        offer(16'h0987);
        run(F + 8);

        run_to(3);
        offer(16'h4321);
        run_to(21);
        #2 reset_n = 1'b0;
        #1 chk_reset("async");
        sb.delete();
        disp  = '0;
        err_m = 1'b0;
        rdy_m = 1'b1;
        @(negedge clk);
        chk_reset("held");
        reset_n = 1'b1;
        c = -1;
        run(2 * F + 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
